avl_mem_responder: RTL and testbench

Avalon-MM responder that emulates the DDR3 controller's local (avl_*) interface from on-chip RAM. It lets the DDR3 load/store engine and its buffers be brought up and regression-tested without the external memory or controller IP. It answers single-beat 128-bit reads and writes with programmable stall and read latency. Its handshake matches the team's DDR3 initiator exactly, including that initiator's one-cycle-late request deassertion.

---
 rtl/avl_mem_pkg.sv | 17 +
 rtl/avl_mem_responder_if.sv | 39 +++
 rtl/avl_mem_ram.sv | 29 ++
 rtl/avl_mem_responder.sv | 155 +++++++++++++++
 tb/tb_avl_mem_responder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/avl_mem_pkg.sv
// rtl/avl_mem_pkg.sv - shared constants, FSM state type and default timing for the Avalon-MM RAM responder
package avl_mem_pkg;

  localparam int AVL_ADDR_W = 26;
  localparam int AVL_DATA_W = 128;

  localparam int AVL_DEF_WAIT_CYCLES  = 1;
  localparam int AVL_DEF_READ_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    ACCEPT = 2'd2,
    REARM  = 2'd3
  } avl_state_e;

endpackage

// File: rtl/avl_mem_responder_if.sv
// rtl/avl_mem_responder_if.sv - avl_* local-interface bundle between DDR3 initiator (master) and responder (slave)
// avl_oob_err exists only when AVL_MEM_BOUNDS_EN is defined.
interface avl_mem_responder_if;
  import avl_mem_pkg::*;

  logic [AVL_ADDR_W-1:0] avl_address;
  logic                  avl_burstbegin;
  logic                  avl_read;
  logic                  avl_write;
  logic [AVL_DATA_W-1:0] avl_writedata;
  logic                  avl_wait_request_n;
  logic                  avl_readdatavalid;
  logic [AVL_DATA_W-1:0] avl_readdata;

`ifdef AVL_MEM_BOUNDS_EN
  logic                  avl_oob_err;

  modport slave (
    input  avl_address, avl_burstbegin, avl_read, avl_write, avl_writedata,
    output avl_wait_request_n, avl_readdatavalid, avl_readdata, avl_oob_err
  );

  modport master (
    output avl_address, avl_burstbegin, avl_read, avl_write, avl_writedata,
    input  avl_wait_request_n, avl_readdatavalid, avl_readdata, avl_oob_err
  );
`else
  modport slave (
    input  avl_address, avl_burstbegin, avl_read, avl_write, avl_writedata,
    output avl_wait_request_n, avl_readdatavalid, avl_readdata
  );

  modport master (
    output avl_address, avl_burstbegin, avl_read, avl_write, avl_writedata,
    input  avl_wait_request_n, avl_readdatavalid, avl_readdata
  );
`endif

endinterface

// File: rtl/avl_mem_ram.sv
// rtl/avl_mem_ram.sv - single-port synchronous RAM, one-cycle read, write-first
module avl_mem_ram
  import avl_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [AVL_DATA_W-1:0] i_wdata,
  output logic [AVL_DATA_W-1:0] o_rdata
);

  logic [AVL_DATA_W-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [AVL_DATA_W-1:0] r_rdata;

  // Write-first port: a written word appears on the read output in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avl_mem_responder.sv
// rtl/avl_mem_responder.sv - Avalon-MM responder emulating the DDR3 controller local interface from on-chip RAM
// Optional build macro AVL_MEM_BOUNDS_EN: addresses >= 2^ADDR_WIDTH are trapped and flagged on avl_oob_err.
module avl_mem_responder
  import avl_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int WAIT_CYCLES  = AVL_DEF_WAIT_CYCLES,
  parameter int READ_LATENCY = AVL_DEF_READ_LATENCY
) (
  input logic                iCLK,
  input logic                iRST_N,
  avl_mem_responder_if.slave avl
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  avl_state_e            r_state, w_state_nxt;
  logic [3:0]            r_stall_cnt, w_stall_cnt_nxt;
  logic                  r_wait_req_n, w_wait_req_n_nxt;
  logic                  w_req, w_wr_exec, w_rd_exec, w_ram_we;
  logic [AVL_DATA_W-1:0] w_ram_q, w_ram_dat, w_tail_dat;
  logic                  r_ram_vld, w_tail_vld;
  logic                  r_rd_vld;
  logic [AVL_DATA_W-1:0] r_rd_dat;
  logic                  w_unused;

  assign w_req     = avl.avl_read | avl.avl_write;
  assign w_wr_exec = (r_state == ACCEPT) & avl.avl_write;
  // A simultaneous read+write is a protocol error: the write wins and the read is dropped
  assign w_rd_exec = (r_state == ACCEPT) & avl.avl_read & ~avl.avl_write;
  assign w_unused  = ^{avl.avl_burstbegin, avl.avl_address[AVL_ADDR_W-1:ADDR_WIDTH]};

`ifdef AVL_MEM_BOUNDS_EN
  logic w_oob, r_ram_oob, r_oob_err;

  assign w_oob     = |avl.avl_address[AVL_ADDR_W-1:ADDR_WIDTH];
  assign w_ram_we  = w_wr_exec & ~w_oob;
  assign w_ram_dat = r_ram_oob ? '1 : w_ram_q;

  // Tag the RAM output cycle so an out-of-range read returns all-ones
  always_ff @(posedge iCLK) begin
    if (!iRST_N) r_ram_oob <= 1'b0;
    else         r_ram_oob <= w_oob;
  end

  // Sticky out-of-range flag, set by any accepted command to an unmapped address
  always_ff @(posedge iCLK) begin
    if (!iRST_N)                            r_oob_err <= 1'b0;
    else if ((w_wr_exec | w_rd_exec) & w_oob) r_oob_err <= 1'b1;
  end

  assign avl.avl_oob_err = r_oob_err;
`else
  assign w_ram_we  = w_wr_exec;
  assign w_ram_dat = w_ram_q;
`endif

  avl_mem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk   (iCLK),
    .i_we    (w_ram_we),
    .i_addr  (avl.avl_address[ADDR_WIDTH-1:0]),
    .i_wdata (avl.avl_writedata),
    .o_rdata (w_ram_q)
  );

  // Command FSM next state: stall, one-cycle accept strobe, then rearm once requests drop
  always_comb begin
    w_state_nxt      = r_state;
    w_stall_cnt_nxt  = r_stall_cnt;
    w_wait_req_n_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt     = STALL;
          w_stall_cnt_nxt = LP_WAIT;
        end
      end
      STALL: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_stall_cnt == 4'd0) begin
          w_state_nxt      = ACCEPT;
          w_wait_req_n_nxt = 1'b1;
        end else begin
          w_stall_cnt_nxt = r_stall_cnt - 4'd1;
        end
      end
      ACCEPT: w_state_nxt = REARM;
      REARM: begin
        if (!w_req) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command FSM registers
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state      <= IDLE;
      r_stall_cnt  <= 4'd0;
      r_wait_req_n <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_wait_req_n <= w_wait_req_n_nxt;
    end
  end

  // Marks the cycle in which the RAM output carries an accepted read
  always_ff @(posedge iCLK) begin
    if (!iRST_N) r_ram_vld <= 1'b0;
    else         r_ram_vld <= w_rd_exec;
  end

  generate
    if (READ_LATENCY == 1) begin : g_no_dl
      assign w_tail_vld = r_ram_vld;
      assign w_tail_dat = w_ram_dat;
    end else begin : g_dl
      logic [READ_LATENCY-2:0] r_vld_dl;
      logic [AVL_DATA_W-1:0]   r_dat_dl [READ_LATENCY-1];

      // Valid/data delay line; overlapping reads shift through in order
      always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
          r_vld_dl <= '0;
        end else begin
          r_vld_dl[0] <= r_ram_vld;
          for (int k = 1; k < READ_LATENCY - 1; k++) r_vld_dl[k] <= r_vld_dl[k-1];
        end
        r_dat_dl[0] <= w_ram_dat;
        for (int k = 1; k < READ_LATENCY - 1; k++) r_dat_dl[k] <= r_dat_dl[k-1];
      end

      assign w_tail_vld = r_vld_dl[READ_LATENCY-2];
      assign w_tail_dat = r_dat_dl[READ_LATENCY-2];
    end
  endgenerate

  // Read output register; data holds its last beat between strobes
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_rd_vld <= 1'b0;
      r_rd_dat <= '0;
    end else begin
      r_rd_vld <= w_tail_vld;
      if (w_tail_vld) r_rd_dat <= w_tail_dat;
    end
  end

  assign avl.avl_wait_request_n = r_wait_req_n;
  assign avl.avl_readdatavalid  = r_rd_vld;
  assign avl.avl_readdata       = r_rd_dat;

endmodule

// File: tb/tb_avl_mem_responder.sv
// tb/tb_avl_mem_responder.sv - directed table-driven bench for avl_mem_responder (build with or without AVL_MEM_BOUNDS_EN)
module tb_avl_mem_responder;
  import avl_mem_pkg::*;

  localparam int AW = 10;
  localparam int WC = 1;
  localparam int RL = 4;
`ifdef AVL_MEM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  localparam logic [127:0] D0   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D1   = 128'hDEADBEEF_CAFEF00D_11223344_55667788;
  localparam logic [127:0] D2   = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;
  localparam logic [127:0] D3   = 128'h77777777_00000007_12345678_9ABCDEF0;
  localparam logic [127:0] D4   = 128'hC0FFEE00_BADC0DE0_00000001_80000000;
  localparam logic [127:0] D5   = 128'h33333333_44444444_55555555_66666666;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avl_mem_responder_if avl_if ();

  avl_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC), .READ_LATENCY(RL)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .avl    (avl_if)
  );

  typedef struct {
    string        name;
    logic         rd;
    logic         wr;
    logic [25:0]  addr;
    logic [127:0] wdata;
    bit           hold;
    int           exp_acc;
    int           exp_beats;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t         vecs [13];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           acc_cnt  = 0;
  logic [127:0] beat_q [$];
  int           beat_cyc_q [$];
  logic [127:0] last_data = '0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (avl_if.avl_wait_request_n === 1'b1) acc_cnt++;
      if (avl_if.avl_readdatavalid === 1'b1) begin
        beat_q.push_back(avl_if.avl_readdata);
        beat_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input string nm, input logic rd, input logic wr, input logic [25:0] addr,
                         input logic [127:0] wd, input bit hold, input bit rstp,
                         input int exp_acc, input int exp_beats, input logic [127:0] exp_d);
    int a0, c0, cs, n;
    bit seen;
    a0 = acc_cnt;
    beat_q.delete();
    beat_cyc_q.delete();
    c0   = cyc;
    cs   = -1;
    seen = 1'b0;
    n    = 0;
    avl_if.avl_read      = rd;
    avl_if.avl_write     = wr;
    avl_if.avl_address   = addr;
    avl_if.avl_writedata = wd;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (avl_if.avl_wait_request_n === 1'b1) begin
        seen = 1'b1;
        cs   = cyc;
      end
    end
    chk({nm, "_wreq_seen"}, 128'(seen), 128'(1));
    chk({nm, "_wreq_lat"}, 128'(cs), 128'(c0 + WC + 2));
    if (seen) begin
      @(posedge clk); #1;
      if (hold) begin
        @(posedge clk); #1;
      end
    end
    avl_if.avl_read  = 1'b0;
    avl_if.avl_write = 1'b0;
    if (rstp) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      last_data = '0;
    end
    repeat (RL + 4) @(posedge clk);
    #1;
    chk({nm, "_accepts"}, 128'(acc_cnt - a0), 128'(exp_acc));
    chk({nm, "_beats"}, 128'(beat_q.size()), 128'(exp_beats));
    if (exp_beats > 0 && beat_q.size() > 0) begin
      chk({nm, "_rdata"}, beat_q[0], exp_d);
      chk({nm, "_rlat"}, 128'(beat_cyc_q[0]), 128'(cs + 1 + RL));
      last_data = exp_d;
    end
    chk({nm, "_rdata_hold"}, avl_if.avl_readdata, last_data);
  endtask

  initial begin
    int a0;
    vecs[0]  = '{"wr5",       1'b0, 1'b1, 26'd5,    D0,     1'b0, 1, 0, 128'd0};
    vecs[1]  = '{"rd5",       1'b1, 1'b0, 26'd5,    128'd0, 1'b0, 1, 1, D0};
    vecs[2]  = '{"wr0",       1'b0, 1'b1, 26'd0,    D1,     1'b0, 1, 0, 128'd0};
    vecs[3]  = '{"rd0",       1'b1, 1'b0, 26'd0,    128'd0, 1'b0, 1, 1, D1};
    vecs[4]  = '{"wr1023",    1'b0, 1'b1, 26'd1023, D2,     1'b0, 1, 0, 128'd0};
    vecs[5]  = '{"rd1023",    1'b1, 1'b0, 26'd1023, 128'd0, 1'b0, 1, 1, D2};
    vecs[6]  = '{"rd5_hold",  1'b1, 1'b0, 26'd5,    128'd0, 1'b1, 1, 1, D0};
    vecs[7]  = '{"rdwr7",     1'b1, 1'b1, 26'd7,    D3,     1'b0, 1, 0, 128'd0};
    vecs[8]  = '{"rd7",       1'b1, 1'b0, 26'd7,    128'd0, 1'b0, 1, 1, D3};
    vecs[9]  = '{"wr3",       1'b0, 1'b1, 26'd3,    D5,     1'b0, 1, 0, 128'd0};
    vecs[10] = '{"wr1027",    1'b0, 1'b1, 26'd1027, D4,     1'b0, 1, 0, 128'd0};
    vecs[11] = '{"rd3",       1'b1, 1'b0, 26'd3,    128'd0, 1'b0, 1, 1, BOUNDS ? D5 : D4};
    vecs[12] = '{"rd1027",    1'b1, 1'b0, 26'd1027, 128'd0, 1'b0, 1, 1, BOUNDS ? ONES : D4};

    avl_if.avl_address    = '0;
    avl_if.avl_burstbegin = 1'b0;
    avl_if.avl_read       = 1'b0;
    avl_if.avl_write      = 1'b0;
    avl_if.avl_writedata  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wreq_n", 128'(avl_if.avl_wait_request_n), 128'(0));
    chk("reset_rvalid", 128'(avl_if.avl_readdatavalid), 128'(0));
    chk("reset_rdata", avl_if.avl_readdata, 128'd0);
`ifdef AVL_MEM_BOUNDS_EN
    chk("reset_oob_err", 128'(avl_if.avl_oob_err), 128'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
              1'b0, vecs[i].exp_acc, vecs[i].exp_beats, vecs[i].exp_rdata);
    end

`ifdef AVL_MEM_BOUNDS_EN
    chk("oob_err_set", 128'(avl_if.avl_oob_err), 128'(1));
`endif

    // Request dropped during STALL: no accept, RAM untouched
    a0 = acc_cnt;
    avl_if.avl_write     = 1'b1;
    avl_if.avl_address   = 26'd5;
    avl_if.avl_writedata = D4;
    @(posedge clk); #1;
    avl_if.avl_write = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("drop_accepts", 128'(acc_cnt - a0), 128'(0));
    run_cmd("drop_rd5", 1'b1, 1'b0, 26'd5, 128'd0, 1'b0, 1'b0, 1, 1, D0);

    // Reset while a read is in the delay line: beat discarded, RAM kept
    run_cmd("rst_rd0", 1'b1, 1'b0, 26'd0, 128'd0, 1'b0, 1'b1, 1, 0, 128'd0);
`ifdef AVL_MEM_BOUNDS_EN
    chk("oob_err_cleared", 128'(avl_if.avl_oob_err), 128'(0));
`endif
    run_cmd("post_rst_rd0", 1'b1, 1'b0, 26'd0, 128'd0, 1'b0, 1'b0, 1, 1, D1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
